// File: rtl/wbu_writeback.sv
// Writeback stage: accepts one retired instruction, formats load data,
// pulses the register-file write port for one cycle, then commits.
module wbu_writeback #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic              in_rf_wen,
  input  logic [1:0]        in_wb_sel,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_csr_rdata,
  input  logic [2:0]        in_load_fmt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rf_wen,
  output logic [RIDX_W-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [XLEN-1:0]   commit_pc
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;
  localparam logic [1:0] COMMIT   = 2'd3;

  logic [1:0]        state;
  logic [XLEN-1:0]   pc_q;
  logic [RIDX_W-1:0] rd_q;
  logic              wen_q;
  logic [2:0]        fmt_q;
  logic [1:0]        off_q;
  logic [XLEN-1:0]   data_q;
  logic [RIDX_W-1:0] hold_waddr;
  logic [XLEN-1:0]   hold_wdata;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   load_data;

  // Only the low two address bits matter once the load has been issued.
  always_comb begin
    ld_byte = '0;
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (fmt_q)
      3'd0:    load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'd1:    load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'd4:    load_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'd5:    load_data = {{(XLEN-16){1'b0}}, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_q       <= '0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      fmt_q      <= '0;
      off_q      <= '0;
      data_q     <= '0;
      hold_waddr <= '0;
      hold_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pc_q  <= in_pc;
            rd_q  <= in_rd;
            wen_q <= in_rf_wen;
            fmt_q <= in_load_fmt;
            off_q <= in_alu_result[1:0];
            case (in_wb_sel)
              2'd2:    data_q <= in_pc + XLEN'(4);
              2'd3:    data_q <= in_csr_rdata;
              default: data_q <= in_alu_result;
            endcase
            state <= (in_wb_sel == 2'd1) ? WAIT_MEM : WRITE;
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            data_q <= load_data;
            state  <= WRITE;
          end
        end
        WRITE: begin
          hold_waddr <= rd_q;
          hold_wdata <= data_q;
          state      <= commit_ready ? IDLE : COMMIT;
        end
        default: begin
          if (commit_ready) state <= IDLE;
        end
      endcase
    end
  end

  // Write-port fields show the live instruction only in WRITE and
  // otherwise keep presenting whatever was last written.
  assign in_ready     = (state == IDLE);
  assign rf_wen       = (state == WRITE) && wen_q && (rd_q != '0);
  assign rf_waddr     = (state == WRITE) ? rd_q   : hold_waddr;
  assign rf_wdata     = (state == WRITE) ? data_q : hold_wdata;
  assign commit_valid = (state == WRITE) || (state == COMMIT);
  assign commit_pc    = pc_q;

endmodule

// File: tb/tb_wbu_writeback.sv
// Self-checking bench for wbu_writeback: table-driven instructions with a
// scoreboard of expected register writes, plus reset-abort sequence.
module tb_wbu_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, in_rf_wen;
  logic [31:0] in_pc, in_alu_result, in_csr_rdata;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_load_fmt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_valid, commit_ready;
  logic [31:0] commit_pc;

  always #5 clk = ~clk;

  wbu_writeback #(.XLEN(32), .RIDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
    .in_rf_wen(in_rf_wen), .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
    .in_csr_rdata(in_csr_rdata), .in_load_fmt(in_load_fmt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] csr;
    logic [2:0]  fmt;
    logic [31:0] mem;
    int unsigned mem_dly;
    int unsigned cr_lo;
    logic        exp_wen;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[21];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write-cycle monitor: pops the scoreboard on the first commit cycle and
  // checks that the write port is quiet and held everywhere else.
  logic        pending = 1'b0;
  logic [4:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;

  always @(negedge clk) begin
    if (rst) begin
      pending    = 1'b0;
      last_waddr = '0;
      last_wdata = '0;
    end else begin
      if (commit_valid && !pending) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got unexpected write cycle, expected none");
        end else begin
          mon_e = sb.pop_front();
          chk("rf_wen", 32'(rf_wen), 32'(mon_e.wen));
          chk("rf_waddr", 32'(rf_waddr), 32'(mon_e.waddr));
          chk("rf_wdata", rf_wdata, mon_e.wdata);
          chk("commit_pc", commit_pc, mon_e.pc);
          last_waddr = mon_e.waddr;
          last_wdata = mon_e.wdata;
        end
      end else begin
        chk("rf_wen_quiet", 32'(rf_wen), 32'd0);
        chk("waddr_hold", 32'(rf_waddr), 32'(last_waddr));
        chk("wdata_hold", rf_wdata, last_wdata);
      end
      pending = commit_valid && !commit_ready;
    end
  end

  task automatic issue(input vec_t v);
    exp_t e;
    int unsigned k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_before_issue", 32'(in_ready), 32'd1);
    in_pc         = v.pc;
    in_rd         = v.rd;
    in_rf_wen     = v.wen;
    in_wb_sel     = v.sel;
    in_alu_result = v.alu;
    in_csr_rdata  = v.csr;
    in_load_fmt   = v.fmt;
    in_valid      = 1'b1;
    commit_ready  = 1'b0;
    mem_rvalid    = (v.sel == 2'd1) ? 1'b0 : 1'($urandom_range(0, 1));
    mem_rdata     = $urandom;
    e.wen   = v.exp_wen;
    e.waddr = v.rd;
    e.wdata = v.exp_wdata;
    e.pc    = v.pc;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid      = 1'b0;
    in_pc         = $urandom;
    in_rd         = 5'($urandom);
    in_rf_wen     = 1'($urandom);
    in_wb_sel     = 2'($urandom);
    in_alu_result = $urandom;
    in_csr_rdata  = $urandom;
    in_load_fmt   = 3'($urandom);
    if (v.sel == 2'd1) begin
      mem_rvalid = 1'b0;
      for (int unsigned d = 0; d < v.mem_dly; d++) begin
        @(negedge clk);
        chk("wait_in_ready", 32'(in_ready), 32'd0);
        chk("wait_commit", 32'(commit_valid), 32'd0);
        @(posedge clk); #1;
      end
      mem_rdata  = v.mem;
      mem_rvalid = 1'b1;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    for (int unsigned c = 0; c <= v.cr_lo; c++) begin
      if (c == v.cr_lo) commit_ready = 1'b1;
      @(negedge clk);
      chk("commit_valid_hold", 32'(commit_valid), 32'd1);
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    commit_ready = 1'b0;
    mem_rvalid   = 1'b0;
    @(negedge clk);
    chk("back_idle", 32'(in_ready), 32'd1);
    chk("commit_valid_idle", 32'(commit_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_pc = '0; in_rd = '0; in_rf_wen = 1'b0; in_wb_sel = '0;
    in_alu_result = '0; in_csr_rdata = '0; in_load_fmt = '0;
    mem_rvalid = 1'b0; mem_rdata = '0; commit_ready = 1'b0;

    //          pc            rd     wen   sel   alu           csr           fmt   mem           dly cr  ewen  ewdata
    tbl[0]  = '{32'h0000_1000, 5'd5,  1'b1, 2'd0, 32'h1234_5678, 32'h0,        3'd0, 32'h0,        0,  0,  1'b1, 32'h1234_5678};
    tbl[1]  = '{32'h0000_1004, 5'd7,  1'b1, 2'd1, 32'h8000_0003, 32'h0,        3'd0, 32'h80FF_0000, 0,  0,  1'b1, 32'hFFFF_FF80};
    tbl[2]  = '{32'h0000_1008, 5'd7,  1'b1, 2'd1, 32'h8000_0003, 32'h0,        3'd4, 32'h80FF_0000, 0,  0,  1'b1, 32'h0000_0080};
    tbl[3]  = '{32'h0000_100C, 5'd7,  1'b1, 2'd1, 32'h8000_0002, 32'h0,        3'd1, 32'h80FF_0000, 0,  0,  1'b1, 32'hFFFF_80FF};
    tbl[4]  = '{32'h0000_1010, 5'd8,  1'b1, 2'd1, 32'h8000_0003, 32'h0,        3'd5, 32'h80FF_0000, 0,  1,  1'b1, 32'h0000_80FF};
    tbl[5]  = '{32'h0000_1014, 5'd9,  1'b1, 2'd1, 32'h8000_0001, 32'h0,        3'd1, 32'h1234_8765, 0,  0,  1'b1, 32'hFFFF_8765};
    tbl[6]  = '{32'h0000_1018, 5'd10, 1'b1, 2'd1, 32'h8000_0000, 32'h0,        3'd2, 32'hDEAD_BEEF, 0,  0,  1'b1, 32'hDEAD_BEEF};
    tbl[7]  = '{32'h0000_101C, 5'd11, 1'b1, 2'd1, 32'h8000_0001, 32'h0,        3'd3, 32'hCAFE_F00D, 0,  0,  1'b1, 32'hCAFE_F00D};
    tbl[8]  = '{32'h0000_1020, 5'd12, 1'b1, 2'd1, 32'h8000_0002, 32'h0,        3'd6, 32'h0BAD_CAFE, 0,  0,  1'b1, 32'h0BAD_CAFE};
    tbl[9]  = '{32'h0000_1024, 5'd13, 1'b1, 2'd1, 32'h8000_0003, 32'h0,        3'd7, 32'h7654_3210, 0,  0,  1'b1, 32'h7654_3210};
    tbl[10] = '{32'h0000_1028, 5'd14, 1'b1, 2'd1, 32'h8000_0001, 32'h0,        3'd0, 32'h0000_7F00, 0,  0,  1'b1, 32'h0000_007F};
    tbl[11] = '{32'h0000_102C, 5'd15, 1'b1, 2'd1, 32'h8000_0002, 32'h0,        3'd4, 32'h00AB_0000, 0,  0,  1'b1, 32'h0000_00AB};
    tbl[12] = '{32'hFFFF_FFFC, 5'd1,  1'b1, 2'd2, 32'h1111_1111, 32'h0,        3'd0, 32'h0,        0,  0,  1'b1, 32'h0000_0000};
    tbl[13] = '{32'h0000_2000, 5'd1,  1'b1, 2'd2, 32'h2222_2222, 32'h0,        3'd0, 32'h0,        0,  0,  1'b1, 32'h0000_2004};
    tbl[14] = '{32'h0000_3000, 5'd31, 1'b1, 2'd3, 32'h0000_1111, 32'hA5A5_0001, 3'd0, 32'h0,        0,  3,  1'b1, 32'hA5A5_0001};
    tbl[15] = '{32'h0000_3004, 5'd0,  1'b1, 2'd0, 32'h5555_AAAA, 32'h0,        3'd0, 32'h0,        0,  0,  1'b0, 32'h5555_AAAA};
    tbl[16] = '{32'h0000_3008, 5'd9,  1'b0, 2'd0, 32'h0F0F_0F0F, 32'h0,        3'd0, 32'h0,        0,  0,  1'b0, 32'h0F0F_0F0F};
    tbl[17] = '{32'h0000_300C, 5'd3,  1'b1, 2'd1, 32'h8000_0010, 32'h0,        3'd2, 32'h1357_9BDF, 4,  2,  1'b1, 32'h1357_9BDF};
    tbl[18] = '{32'h0000_3010, 5'd20, 1'b1, 2'd1, 32'h8000_0003, 32'h0,        3'd1, 32'h8001_0000, 2,  0,  1'b1, 32'hFFFF_8001};
    tbl[19] = '{32'h0000_3014, 5'd21, 1'b1, 2'd1, 32'h8000_0000, 32'h0,        3'd0, 32'h1234_56F0, 0,  0,  1'b1, 32'hFFFF_FFF0};
    tbl[20] = '{32'h0000_3018, 5'd22, 1'b1, 2'd1, 32'h8000_0000, 32'h0,        3'd5, 32'h0000_9ABC, 1,  1,  1'b1, 32'h0000_9ABC};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_commit_pc", commit_pc, 32'd0);

    for (int i = 0; i < 21; i++) issue(tbl[i]);

    // Load aborted by reset while waiting, with data arriving on the reset edge.
    in_pc = 32'h0000_4000; in_rd = 5'd4; in_rf_wen = 1'b1; in_wb_sel = 2'd1;
    in_alu_result = 32'h8000_0000; in_load_fmt = 3'd2; in_valid = 1'b1;
    commit_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_wait_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFEED_FACE;
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_commit", 32'(commit_valid), 32'd0);
      chk("abort_rf_wen", 32'(rf_wen), 32'd0);
    end
    commit_ready = 1'b0;

    issue('{32'h0000_5000, 5'd6, 1'b1, 2'd0, 32'h0BEE_F00D, 32'h0, 3'd0, 32'h0, 0, 0, 1'b1, 32'h0BEE_F00D});

    repeat (2) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
